// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between a crossbar master port and axi_sram_slave.
// Signal suffixes are named from the slave's point of view.
interface axi_sram_slave_if #(
  parameter int ID_W = 8
);
  logic [ID_W-1:0] ARID_i;
  logic [31:0]     ARADDR_i;
  logic [3:0]      ARLEN_i;
  logic [2:0]      ARSIZE_i;
  logic [1:0]      ARBURST_i;
  logic            ARVALID_i;
  logic            ARREADY_o;
  logic [ID_W-1:0] RID_o;
  logic [31:0]     RDATA_o;
  logic [1:0]      RRESP_o;
  logic            RLAST_o;
  logic            RVALID_o;
  logic            RREADY_i;
  logic [ID_W-1:0] AWID_i;
  logic [31:0]     AWADDR_i;
  logic [3:0]      AWLEN_i;
  logic [2:0]      AWSIZE_i;
  logic [1:0]      AWBURST_i;
  logic            AWVALID_i;
  logic            AWREADY_o;
  logic [31:0]     WDATA_i;
  logic [3:0]      WSTRB_i;
  logic            WLAST_i;
  logic            WVALID_i;
  logic            WREADY_o;
  logic [ID_W-1:0] BID_o;
  logic [1:0]      BRESP_o;
  logic            BVALID_o;
  logic            BREADY_i;

  modport slave (
    input  ARID_i, ARADDR_i, ARLEN_i, ARSIZE_i,
    input  ARBURST_i, ARVALID_i, RREADY_i,
    input  AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i,
    input  AWBURST_i, AWVALID_i,
    input  WDATA_i, WSTRB_i, WLAST_i, WVALID_i,
    input  BREADY_i,
    output ARREADY_o, RID_o, RDATA_o, RRESP_o,
    output RLAST_o, RVALID_o, AWREADY_o, WREADY_o,
    output BID_o, BRESP_o, BVALID_o
  );

  modport master (
    output ARID_i, ARADDR_i, ARLEN_i, ARSIZE_i,
    output ARBURST_i, ARVALID_i, RREADY_i,
    output AWID_i, AWADDR_i, AWLEN_i, AWSIZE_i,
    output AWBURST_i, AWVALID_i,
    output WDATA_i, WSTRB_i, WLAST_i, WVALID_i,
    output BREADY_i,
    input  ARREADY_o, RID_o, RDATA_o, RRESP_o,
    input  RLAST_o, RVALID_o, AWREADY_o, WREADY_o,
    input  BID_o, BRESP_o, BVALID_o
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave terminating one crossbar port onto a single-port SRAM.
// Define AXI_SRAM_DECERR_EN to answer out-of-window bursts with DECERR.
module axi_sram_slave #(
  parameter int ID_W     = 8,
  parameter int MEM_AW   = 14,
  parameter int RD_DEPTH = 2
) (
  input  logic              SRAM_CLK_i,
  input  logic              SRAM_RST_i,
  axi_sram_slave_if.slave   s_axi,
  output logic              MEM_CS_o,
  output logic [3:0]        MEM_WE_o,
  output logic [MEM_AW-1:0] MEM_A_o,
  output logic [31:0]       MEM_DI_o,
  input  logic [31:0]       MEM_DO_i
);

  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = $clog2(RD_DEPTH + 2);

  typedef enum logic [1:0] {
    S_IDLE, S_RD, S_WR, S_RESP
  } state_t;

  state_t            r_st, w_nst;
  logic [ID_W-1:0]   r_id;
  logic [MEM_AW-1:0] r_addr;
  logic [3:0]        r_len, r_beat;
  logic [4:0]        r_iss;
  logic              r_fixed, r_dec, r_err;
  logic              r_last_w, r_infl;
  logic [31:0]       r_buf [RD_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_cnt;

  logic              w_ar, w_aw, w_iss, w_pop;
  logic              w_wfire, w_rv, w_dec;
  logic [31:0]       w_aaddr;
  logic [1:0]        w_burst;

  function automatic logic [PW-1:0] f_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(RD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_rv    = (r_cnt != '0);
  assign w_aaddr = w_ar ? s_axi.ARADDR_i : s_axi.AWADDR_i;
  assign w_burst = w_ar ? s_axi.ARBURST_i : s_axi.AWBURST_i;

`ifdef AXI_SRAM_DECERR_EN
  assign w_dec = |w_aaddr[31:MEM_AW+2];
  logic w_unused;
  assign w_unused = ^{s_axi.ARSIZE_i, s_axi.AWSIZE_i,
                      w_aaddr[1:0]};
`else
  assign w_dec = 1'b0;
  logic w_unused;
  assign w_unused = ^{s_axi.ARSIZE_i, s_axi.AWSIZE_i,
                      w_aaddr[1:0], w_aaddr[31:MEM_AW+2]};
`endif

  always_comb begin
    w_nst   = r_st;
    w_ar    = 1'b0;
    w_aw    = 1'b0;
    w_iss   = 1'b0;
    w_pop   = 1'b0;
    w_wfire = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        // ties alternate; after reset the write side wins first
        w_aw = SRAM_RST_i && s_axi.AWVALID_i &&
               (!s_axi.ARVALID_i || !r_last_w);
        w_ar = SRAM_RST_i && s_axi.ARVALID_i && !w_aw;
        if (w_aw)      w_nst = S_WR;
        else if (w_ar) w_nst = S_RD;
      end
      S_RD: begin
        w_pop = w_rv && s_axi.RREADY_i;
        w_iss = (r_iss <= {1'b0, r_len}) &&
                (r_cnt + CW'(r_infl) <
                 CW'(RD_DEPTH) + CW'(w_pop));
        if (w_pop && r_beat == r_len) w_nst = S_IDLE;
      end
      S_WR: begin
        w_wfire = s_axi.WVALID_i;
        if (w_wfire && r_beat == r_len) w_nst = S_RESP;
      end
      S_RESP: begin
        if (s_axi.BREADY_i) w_nst = S_IDLE;
      end
      default: w_nst = S_IDLE;
    endcase
  end

  always_ff @(posedge SRAM_CLK_i or negedge SRAM_RST_i) begin
    if (!SRAM_RST_i) begin
      r_st     <= S_IDLE;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_beat   <= '0;
      r_iss    <= '0;
      r_fixed  <= 1'b0;
      r_dec    <= 1'b0;
      r_err    <= 1'b0;
      r_last_w <= 1'b0;
      r_infl   <= 1'b0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < RD_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_st   <= w_nst;
      r_infl <= w_iss;
      if (w_ar || w_aw) begin
        r_id     <= w_ar ? s_axi.ARID_i : s_axi.AWID_i;
        r_addr   <= w_aaddr[MEM_AW+1:2];
        r_len    <= w_ar ? s_axi.ARLEN_i : s_axi.AWLEN_i;
        r_fixed  <= (w_burst == 2'b00);
        r_dec    <= w_dec;
        r_beat   <= '0;
        r_iss    <= '0;
        r_err    <= 1'b0;
        r_last_w <= w_aw;
      end
      if ((w_iss || w_wfire) && !r_fixed)
        r_addr <= r_addr + MEM_AW'(1);
      if (w_iss) r_iss <= r_iss + 5'd1;
      if (w_pop || w_wfire) r_beat <= r_beat + 4'd1;
      if (w_wfire && (s_axi.WLAST_i != (r_beat == r_len)))
        r_err <= 1'b1;
      // SRAM data lands one cycle after the access
      if (r_infl) begin
        r_buf[r_wp] <= r_dec ? 32'h0 : MEM_DO_i;
        r_wp        <= f_inc(r_wp);
      end
      if (w_pop) r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + CW'(r_infl) - CW'(w_pop);
    end
  end

  assign s_axi.ARREADY_o = w_ar;
  assign s_axi.AWREADY_o = w_aw;
  assign s_axi.WREADY_o  = (r_st == S_WR);
  assign s_axi.RVALID_o  = w_rv;
  assign s_axi.RDATA_o   = w_rv ? r_buf[r_rp] : 32'h0;
  assign s_axi.RID_o     = r_id;
  assign s_axi.RLAST_o   = w_rv && (r_beat == r_len);
  assign s_axi.RRESP_o   = (w_rv && r_dec) ? 2'b11 : 2'b00;
  assign s_axi.BVALID_o  = (r_st == S_RESP);
  assign s_axi.BID_o     = r_id;
  assign s_axi.BRESP_o   = (r_st != S_RESP) ? 2'b00 :
                           r_dec ? 2'b11 :
                           r_err ? 2'b10 : 2'b00;

  assign MEM_CS_o = !r_dec && (w_iss || w_wfire);
  assign MEM_WE_o = (!r_dec && w_wfire) ? s_axi.WSTRB_i : 4'h0;
  assign MEM_A_o  = r_addr;
  assign MEM_DI_o = w_wfire ? s_axi.WDATA_i : 32'h0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed vector table, corner sequences
// and randomized bursts against a transaction-level memory model.
`timescale 1ns/1ps
module tb_axi_sram_slave;
  localparam int ID_W   = 8;
  localparam int MEM_AW = 14;
  localparam int DEPTH  = 1 << MEM_AW;
`ifdef AXI_SRAM_DECERR_EN
  localparam logic [1:0]  DR       = 2'b11;
  localparam logic [31:0] ALIAS_D0 = 32'h0;
`else
  localparam logic [1:0]  DR       = 2'b00;
  localparam logic [31:0] ALIAS_D0 = 32'hDEADBEEF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.ID_W(ID_W)) bus();
  logic              MEM_CS_o;
  logic [3:0]        MEM_WE_o;
  logic [MEM_AW-1:0] MEM_A_o;
  logic [31:0]       MEM_DI_o;
  logic [31:0]       MEM_DO_i;

  axi_sram_slave #(
    .ID_W(ID_W), .MEM_AW(MEM_AW), .RD_DEPTH(2)
  ) dut (
    .SRAM_CLK_i(clk),
    .SRAM_RST_i(rst_n),
    .s_axi(bus),
    .MEM_CS_o(MEM_CS_o),
    .MEM_WE_o(MEM_WE_o),
    .MEM_A_o(MEM_A_o),
    .MEM_DI_o(MEM_DI_o),
    .MEM_DO_i(MEM_DO_i)
  );

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  int cs_cnt = 0;
  int checks = 0;
  int failures = 0;

  // SRAM macro behaviour
  always @(posedge clk) begin
    if (MEM_CS_o) begin
      cs_cnt <= cs_cnt + 1;
      if (MEM_WE_o == 4'h0) MEM_DO_i <= sram[MEM_A_o];
      else
        for (int j = 0; j < 4; j++)
          if (MEM_WE_o[j])
            sram[MEM_A_o][8*j +: 8] <= MEM_DI_o[8*j +: 8];
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic bit m_dec(input logic [31:0] a);
`ifdef AXI_SRAM_DECERR_EN
    return (a >> (MEM_AW + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_word(input logic [31:0] a);
    return int'(a >> 2) % DEPTH;
  endfunction

  function automatic int m_next(input int w, input logic [1:0] bt);
    return (bt == 2'b00) ? w : (w + 1) % DEPTH;
  endfunction

  task automatic do_read(input logic [ID_W-1:0] id,
                         input logic [31:0] addr,
                         input logic [3:0] len,
                         input logic [1:0] bt,
                         input int rmode,
                         output logic [31:0] d0,
                         output logic [1:0] rsp);
    logic [31:0] exp_d [$];
    logic [31:0] hd;
    logic hl, hv, dec;
    int w, cs0, k, b, lastk;
    dec = m_dec(addr);
    w = m_word(addr);
    for (int i = 0; i <= int'(len); i++) begin
      exp_d.push_back(dec ? 32'h0 : ref_mem[w]);
      w = m_next(w, bt);
    end
    d0 = '0;
    rsp = '0;
    @(negedge clk);
    bus.ARID_i = id;
    bus.ARADDR_i = addr;
    bus.ARLEN_i = len;
    bus.ARSIZE_i = 3'd2;
    bus.ARBURST_i = bt;
    bus.ARVALID_i = 1'b1;
    #1;
    k = 0;
    while (!bus.ARREADY_o && k < 50) begin
      @(negedge clk); #1; k++;
    end
    chk("ar_hs", bus.ARREADY_o, 1);
    cs0 = cs_cnt;
    b = 0; hv = 0; lastk = 0; hd = '0; hl = 0;
    for (k = 1; k <= 300 && b <= int'(len); k++) begin
      @(negedge clk);
      bus.ARVALID_i = 1'b0;
      case (rmode)
        0: bus.RREADY_i = 1'b1;
        1: bus.RREADY_i = k[0];
        default: bus.RREADY_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (k == 1) chk("rd_cs_t1", MEM_CS_o, !dec);
      if (k == 2) chk("rd_rvalid_t2", bus.RVALID_o, 0);
      if (k == 3) chk("rd_rvalid_t3", bus.RVALID_o, 1);
      if (hv) begin
        chk("rd_stall_data", bus.RDATA_o, hd);
        chk("rd_stall_last", bus.RLAST_o, hl);
      end
      hv = 0;
      if (bus.RVALID_o && bus.RREADY_i) begin
        chk("rd_data", bus.RDATA_o, exp_d[b]);
        chk("rd_resp", bus.RRESP_o, dec ? 2'b11 : 2'b00);
        chk("rd_id", bus.RID_o, id);
        chk("rd_last", bus.RLAST_o, b == int'(len));
        if (b == 0) d0 = bus.RDATA_o;
        rsp = bus.RRESP_o;
        b++;
        lastk = k;
      end else if (bus.RVALID_o) begin
        hv = 1; hd = bus.RDATA_o; hl = bus.RLAST_o;
      end
    end
    chk("rd_beats", b, int'(len) + 1);
    if (rmode == 0) chk("rd_b2b", lastk, 3 + int'(len));
    @(negedge clk);
    bus.RREADY_i = 1'b0;
    chk("rd_sram_cnt", cs_cnt - cs0, dec ? 0 : int'(len) + 1);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id,
                          input logic [31:0] addr,
                          input logic [3:0] len,
                          input logic [1:0] bt,
                          input logic [63:0] strbs,
                          input int bad,
                          input int gapmax,
                          input int bdly,
                          output logic [1:0] rsp);
    logic dec;
    logic [1:0] er;
    logic [3:0] st;
    logic [31:0] wd;
    int w, cs0, k;
    dec = m_dec(addr);
    w = m_word(addr);
    er = dec ? 2'b11 :
         (bad >= 0 && bad <= int'(len)) ? 2'b10 : 2'b00;
    @(negedge clk);
    bus.AWID_i = id;
    bus.AWADDR_i = addr;
    bus.AWLEN_i = len;
    bus.AWSIZE_i = 3'd2;
    bus.AWBURST_i = bt;
    bus.AWVALID_i = 1'b1;
    #1;
    k = 0;
    while (!bus.AWREADY_o && k < 50) begin
      @(negedge clk); #1; k++;
    end
    chk("aw_hs", bus.AWREADY_o, 1);
    cs0 = cs_cnt;
    @(negedge clk);
    bus.AWVALID_i = 1'b0;
    #1;
    chk("wr_wready_t1", bus.WREADY_o, 1);
    for (int b = 0; b <= int'(len); b++) begin
      k = $urandom_range(0, gapmax);
      if (k > 0) begin
        bus.WVALID_i = 1'b0;
        repeat (k) @(negedge clk);
      end
      st = strbs[4*b +: 4];
      wd = $urandom;
      bus.WDATA_i = wd;
      bus.WSTRB_i = st;
      bus.WLAST_i = (b == int'(len)) ^ (b == bad);
      bus.WVALID_i = 1'b1;
      #1;
      chk("wr_wready", bus.WREADY_o, 1);
      chk("wr_cs", MEM_CS_o, !dec);
      chk("wr_we", MEM_WE_o, dec ? 4'h0 : st);
      chk("wr_addr", MEM_A_o, w);
      if (!dec)
        for (int j = 0; j < 4; j++)
          if (st[j]) ref_mem[w][8*j +: 8] = wd[8*j +: 8];
      w = m_next(w, bt);
      @(negedge clk);
    end
    bus.WVALID_i = 1'b0;
    bus.WLAST_i = 1'b0;
    #1;
    chk("wr_bvalid_f1", bus.BVALID_o, 1);
    chk("wr_bid", bus.BID_o, id);
    chk("wr_bresp", bus.BRESP_o, er);
    rsp = bus.BRESP_o;
    repeat (bdly) @(negedge clk);
    bus.BREADY_i = 1'b1;
    #1;
    chk("wr_bhold", bus.BVALID_o, 1);
    @(negedge clk);
    bus.BREADY_i = 1'b0;
    #1;
    chk("wr_bdone", bus.BVALID_o, 0);
    chk("wr_sram_cnt", cs_cnt - cs0, dec ? 0 : int'(len) + 1);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  bt;
    logic [63:0] strb;
    int          bad;
    int          rmode;
    logic [1:0]  exp_resp;
    bit          has_d0;
    logic [31:0] d0;
  } vec_t;

  vec_t vt [13];

  initial begin : main
    logic [31:0] d0;
    logic [1:0]  rsp;
    int grants [4];
    int ng, both, k, hi;

    vt[0]  = '{0, 8'h11, 32'h10,        4'd0, 2'd1, 64'h0,    -1, 0, 2'b00, 1, 32'hDEADBEEF};
    vt[1]  = '{0, 8'h22, 32'h40,        4'd3, 2'd1, 64'h0,    -1, 1, 2'b00, 0, 32'h0};
    vt[2]  = '{1, 8'h33, 32'h20,        4'd1, 2'd1, 64'hF3,   -1, 0, 2'b00, 0, 32'h0};
    vt[3]  = '{1, 8'h44, 32'h100,       4'd2, 2'd1, 64'hFFF,   1, 0, 2'b10, 0, 32'h0};
    vt[4]  = '{1, 8'h45, 32'h104,       4'd2, 2'd1, 64'hFFF,   2, 0, 2'b10, 0, 32'h0};
    vt[5]  = '{0, 8'h55, 32'h20,        4'd3, 2'd0, 64'h0,    -1, 0, 2'b00, 0, 32'h0};
    vt[6]  = '{0, 8'h66, 32'hFFFC,      4'd2, 2'd1, 64'h0,    -1, 0, 2'b00, 0, 32'h0};
    vt[7]  = '{1, 8'h77, 32'hFFF8,      4'd3, 2'd2, 64'hFFFF, -1, 0, 2'b00, 0, 32'h0};
    vt[8]  = '{0, 8'h78, 32'hFFF8,      4'd3, 2'd1, 64'h0,    -1, 2, 2'b00, 0, 32'h0};
    vt[9]  = '{0, 8'h88, 32'h8000_0000, 4'd1, 2'd1, 64'h0,    -1, 0, DR,    0, 32'h0};
    vt[10] = '{0, 8'h89, 32'h0001_0010, 4'd0, 2'd1, 64'h0,    -1, 0, DR,    1, ALIAS_D0};
    vt[11] = '{1, 8'h99, 32'h4000_0040, 4'd1, 2'd1, 64'hFF,   -1, 0, DR,    0, 32'h0};
    vt[12] = '{0, 8'h9A, 32'h40,        4'd1, 2'd1, 64'h0,    -1, 0, 2'b00, 0, 32'h0};

    for (int i = 0; i < DEPTH; i++) begin
      sram[i] = 32'h5A5A_0000 ^ (i * 32'h9E37_79B1);
      ref_mem[i] = sram[i];
    end
    sram[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    MEM_DO_i = '0;
    bus.ARID_i = '0; bus.ARADDR_i = '0; bus.ARLEN_i = '0;
    bus.ARSIZE_i = 3'd2; bus.ARBURST_i = 2'd1;
    bus.AWID_i = '0; bus.AWADDR_i = '0; bus.AWLEN_i = '0;
    bus.AWSIZE_i = 3'd2; bus.AWBURST_i = 2'd1;
    bus.WDATA_i = '0; bus.WSTRB_i = '0; bus.WLAST_i = 1'b1;
    bus.ARVALID_i = 1'b1; bus.AWVALID_i = 1'b1;
    bus.WVALID_i = 1'b1; bus.RREADY_i = 1'b1; bus.BREADY_i = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_arready", bus.ARREADY_o, 0);
    chk("rst_awready", bus.AWREADY_o, 0);
    chk("rst_wready", bus.WREADY_o, 0);
    chk("rst_rvalid", bus.RVALID_o, 0);
    chk("rst_rlast", bus.RLAST_o, 0);
    chk("rst_bvalid", bus.BVALID_o, 0);
    chk("rst_ids", {bus.RID_o, bus.BID_o}, 0);
    chk("rst_rdata", bus.RDATA_o, 0);
    chk("rst_resp", {bus.RRESP_o, bus.BRESP_o}, 0);
    chk("rst_mem", {MEM_CS_o, MEM_WE_o, MEM_A_o, MEM_DI_o}, 0);

    // both address channels held valid out of reset
    @(negedge clk);
    rst_n = 1'b1;
    ng = 0; both = 0;
    for (k = 0; k < 80 && ng < 4; k++) begin
      #1;
      if (bus.ARREADY_o && bus.AWREADY_o) both++;
      if (bus.AWREADY_o) begin grants[ng] = 1; ng++; end
      else if (bus.ARREADY_o) begin grants[ng] = 0; ng++; end
      @(negedge clk);
    end
    bus.ARVALID_i = 1'b0;
    bus.AWVALID_i = 1'b0;
    chk("arb_count", ng, 4);
    chk("arb_both", both, 0);
    for (int i = 0; i < 4 && i < ng; i++)
      chk("arb_order", grants[i], (i % 2 == 0) ? 1 : 0);
    repeat (10) @(negedge clk);
    bus.WVALID_i = 1'b0;
    bus.RREADY_i = 1'b0;
    bus.BREADY_i = 1'b0;
    bus.WLAST_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (vt[i].wr)
        do_write(vt[i].id, vt[i].addr, vt[i].len, vt[i].bt,
                 vt[i].strb, vt[i].bad, 0, 0, rsp);
      else
        do_read(vt[i].id, vt[i].addr, vt[i].len, vt[i].bt,
                vt[i].rmode, d0, rsp);
      chk("vec_resp", rsp, vt[i].exp_resp);
      if (vt[i].has_d0) chk("vec_d0", d0, vt[i].d0);
    end

    // reset during a stalled read burst
    @(negedge clk);
    bus.ARID_i = 8'h5C; bus.ARADDR_i = 32'h40;
    bus.ARLEN_i = 4'd7; bus.ARBURST_i = 2'd1;
    bus.ARVALID_i = 1'b1;
    #1;
    chk("mid_ar_hs", bus.ARREADY_o, 1);
    @(negedge clk);
    bus.ARVALID_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_rvalid", bus.RVALID_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out",
        {bus.RVALID_o, bus.RLAST_o, MEM_CS_o, bus.RDATA_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus.RVALID_o || bus.BVALID_o || MEM_CS_o) hi++;
    end
    chk("mid_quiet", hi, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [3:0]  ln;
      logic [1:0]  bt;
      int bad;
      if ($urandom_range(0, 3) == 0)
        a = 32'(16380 + $urandom_range(0, 3)) << 2;
      else
        a = 32'($urandom_range(0, 63)) << 2;
      a[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0)
        a = a | ($urandom & 32'hFFFF_0000);
      ln = 4'($urandom_range(0, 15));
      bt = 2'($urandom_range(0, 2));
      bad = ($urandom_range(0, 4) == 0) ?
            $urandom_range(0, int'(ln)) : -1;
      if ($urandom_range(0, 1) == 1)
        do_write(8'($urandom), a, ln, bt, {$urandom, $urandom},
                 bad, 2, $urandom_range(0, 3), rsp);
      else
        do_read(8'($urandom), a, ln, bt,
                $urandom_range(0, 2), d0, rsp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 slave-side responder that terminates one crossbar master port (AXI_M_IF side) and drives a single-port synchronous SRAM macro. It accepts AR/AW bursts with the widened crossbar ID, sequences SRAM word accesses, and returns R beats and B responses. Reads are buffered so that a burst sustains one beat per cycle under continuous RREADY. One burst is in flight at a time; reads and writes are serialized.

## Interface
- ID_W, 8, widened slave-side ID width (`AXI_IDS_BITS`)
- MEM_AW, 14, SRAM word-address width (window = 2^(MEM_AW+2) bytes)
- RD_DEPTH, 2, read data buffer entries (≥2)
- SRAM_CLK_i  in  1  clock; all logic on the rising edge
- SRAM_RST_i  in  1  reset, asynchronous, active-low
- ARID_i/ARADDR_i/ARLEN_i/ARSIZE_i/ARBURST_i/ARVALID_i  in  ID_W/32/4/3/2/1  read address channel
- ARREADY_o  out  1
- RID_o/RDATA_o/RRESP_o/RLAST_o/RVALID_o  out  ID_W/32/2/1/1  read data channel
- RREADY_i  in  1
- AWID_i/AWADDR_i/AWLEN_i/AWSIZE_i/AWBURST_i/AWVALID_i  in  ID_W/32/4/3/2/1  write address channel
- AWREADY_o  out  1
- WDATA_i/WSTRB_i/WLAST_i/WVALID_i  in  32/4/1/1  write data channel
- WREADY_o  out  1
- BID_o/BRESP_o/BVALID_o  out  ID_W/2/1  write response channel
- BREADY_i  in  1
- MEM_CS_o  out  1  SRAM access enable
- MEM_WE_o  out  4  byte write enables (all 0 = read)
- MEM_A_o  out  MEM_AW  word address
- MEM_DI_o  out  32  write data
- MEM_DO_i  in  32  read data, valid the cycle after a read access

## Operation
- FSM: IDLE, RD, WR, RESP.
- IDLE: ARREADY_o/AWREADY_o high only in IDLE, at most one high per cycle. Only one valid → grant it. Both valid → grant opposite of last grant; last-grant register resets to "read" (write wins first tie).
- Handshake latches ID, word address ADDR[MEM_AW+1:2], LEN, BURST; beat counter cleared.
- Address update per beat: BURST=FIXED (2'b00) holds address; INCR and WRAP both increment by 1 word, wrapping modulo 2^MEM_AW. ARSIZE/AWSIZE ignored (32-bit beats only).
- RD: issue SRAM read (MEM_CS_o=1, MEM_WE_o=0) when beats remain and occupancy + in-flight − pop_this_cycle < RD_DEPTH. Returned data pushed into buffer next cycle. RVALID_o = buffer non-empty; RDATA_o = head; RID_o = latched ARID; RRESP_o = OKAY; RLAST_o on beat index == ARLEN. Last beat handshake → IDLE.
- WR: WREADY_o=1; each W handshake drives MEM_CS_o=1, MEM_WE_o=WSTRB_i, MEM_DI_o=WDATA_i same cycle. Beat count == AWLEN ends burst → RESP. WLAST_i asserted on any other beat, or deasserted on final beat, sets error flag → BRESP SLVERR (2'b10), else OKAY.
- RESP: BVALID_o=1, BID_o = latched AWID; BREADY_i handshake → IDLE.

## Timing
- Reset: all outputs 0 (ARREADY_o, AWREADY_o, WREADY_o, RVALID_o, BVALID_o, RLAST_o, MEM_CS_o, MEM_WE_o, IDs, data, responses); FSM IDLE; buffer flushed. Reset mid-burst drops the burst, no response generated.
- AR handshake cycle T: first SRAM read in T+1, RVALID_o first high in T+3.
- RREADY_i held high: one R beat per cycle, LEN+1 beats in LEN+1 consecutive cycles.
- RREADY_i low: RDATA_o/RLAST_o/RID_o stable; reads stop at buffer full; no data lost.
- AW handshake cycle T: WREADY_o high from T+1; final W beat cycle F: BVALID_o high F+1.
- Next AR/AW accepted earliest the cycle after the final R or B handshake.
- Simultaneous AR and AW valid: exactly one READY asserted, per alternation rule.

## Configuration
- AXI_SRAM_DECERR_EN defined: burst with any ADDR[31:MEM_AW+2] set performs no SRAM access (MEM_CS_o stays 0); reads return LEN+1 beats of RDATA 0 with RRESP DECERR (2'b11); writes accept all beats, BRESP DECERR.
- Undefined: upper address bits ignored; access aliases into the window.

## Test plan
- Single read: ARADDR 0x10, ARLEN 0, RREADY high, SRAM word 4 = 0xDEADBEEF → one beat RDATA 0xDEADBEEF, RLAST 1, RRESP 0, RVALID at T+3.
- INCR read ARLEN 3, RREADY toggled 1/0 each cycle → 4 beats words n..n+3 in order, data stable while stalled, RLAST only on 4th.
- Write ARLEN… AWLEN 1 at 0x20, WSTRB 4'b0011 then 4'b1111 → MEM_WE_o matches, addresses 8 and 9, BRESP OKAY, BID = AWID.
- AWLEN 2 with WLAST on beat 1 → 3 SRAM writes, BRESP 2'b10.
- AR and AW valid together from reset, held → AW granted first, then AR, then AW alternating.
- AXI_SRAM_DECERR_EN, ARADDR 0x8000_0000 ARLEN 1 → 2 beats RDATA 0, RRESP 2'b11, MEM_CS_o never high.
